// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port among NUM_REQ producers.
// A grantee holds the port for a whole line (until EOL_CHAR) or until it idles out.
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         LOCK_TIMEOUT = 1024,
  parameter logic [7:0] EOL_CHAR     = 8'h0A,
  parameter bit         LINE_LOCK    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_evt
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  idle_cnt;

  logic              found;
  logic [ID_W-1:0]   pick_id;
  logic [7:0]        sel_data;
  logic              accept;
  logic              release_on_accept;
  logic [ID_W-1:0]   next_ptr;

  // Two ordered passes: indices at/after rr_ptr first, then the wrapped-around ones.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr))) begin
        found   = 1'b1;
        pick_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found   = 1'b1;
        pick_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_LOCKED)
      req_ready[grant_id] = req_valid[grant_id] && (!tx_valid || tx_ready);
  end

  assign accept            = |req_ready;
  assign release_on_accept = LINE_LOCK ? (sel_data == EOL_CHAR) : 1'b1;
  assign next_ptr          = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
  assign busy              = (state == S_LOCKED) || tx_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      grant_id    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id <= pick_id;
            idle_cnt <= '0;
            state    <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (accept) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_data;
            idle_cnt <= '0;
            if (release_on_accept) begin
              state  <= S_IDLE;
              rr_ptr <= next_ptr;
            end
          end else if (idle_cnt == CNT_LAST) begin
            // Accept has priority, so only a truly idle final cycle times out.
            state       <= S_IDLE;
            rr_ptr      <= next_ptr;
            timeout_evt <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one line-locked and one per-byte instance share stimulus;
// a vector table, hand-written corner sequences and a queue-based stream scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam logic [7:0] EOL = 8'h0A;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic            tx_ready = 1'b0;

  logic [NR-1:0] a_req_ready, b_req_ready, m_req_ready;
  logic          a_tx_valid, b_tx_valid, m_tx_valid;
  logic [7:0]    a_tx_data, b_tx_data, m_tx_data;
  logic [1:0]    a_grant_id, b_grant_id, m_grant_id;
  logic          a_busy, b_busy, m_busy;
  logic          a_timeout_evt, b_timeout_evt, m_timeout_evt;
  logic          sel = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(8), .EOL_CHAR(EOL), .LINE_LOCK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(a_req_ready),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(tx_ready), .grant_id(a_grant_id),
    .busy(a_busy), .timeout_evt(a_timeout_evt));

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(8), .EOL_CHAR(EOL), .LINE_LOCK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(b_req_ready),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(tx_ready), .grant_id(b_grant_id),
    .busy(b_busy), .timeout_evt(b_timeout_evt));

  assign m_req_ready   = sel ? b_req_ready   : a_req_ready;
  assign m_tx_valid    = sel ? b_tx_valid    : a_tx_valid;
  assign m_tx_data     = sel ? b_tx_data     : a_tx_data;
  assign m_grant_id    = sel ? b_grant_id    : a_grant_id;
  assign m_busy        = sel ? b_busy        : a_busy;
  assign m_timeout_evt = sel ? b_timeout_evt : a_timeout_evt;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Stream scoreboard state: per-requester byte queues and the observed outcome.
  logic [7:0] tq [NR][$];
  logic [7:0] exp_fifo [$];
  logic [7:0] out_log [$];
  int         src_log [$];
  int         tevt_count;

  task automatic run_stream(input bit rnd, input int max_cyc);
    logic [NR-1:0] acc;
    logic [7:0]    b;
    bit            owner_v;
    int            owner;
    bit            done;
    int            cyc;
    owner_v = 1'b0; owner = 0; done = 1'b0; cyc = 0; tevt_count = 0;
    exp_fifo.delete(); out_log.delete(); src_log.delete();
    while (!done && cyc < max_cyc) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i]       = (tq[i].size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        req_data[8*i +: 8] = (tq[i].size() > 0) ? tq[i][0] : 8'h00;
      end
      tx_ready = !rnd || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (m_tx_valid && tx_ready) begin
        check("tx_pending", 32'(exp_fifo.size() > 0), 1);
        if (exp_fifo.size() > 0) check("tx_data", 32'(m_tx_data), 32'(exp_fifo.pop_front()));
        out_log.push_back(m_tx_data);
      end
      acc = req_valid & m_req_ready;
      check("ready_without_valid", 32'(m_req_ready & ~req_valid), 0);
      check("accept_onehot", 32'($countones(acc) <= 1), 1);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          b = tq[i][0];
          exp_fifo.push_back(b);
          src_log.push_back(i);
          if (!sel && owner_v) check("line_lock_owner", i, owner);
          if (b == EOL) owner_v = 1'b0;
          else begin owner_v = 1'b1; owner = i; end
        end
      end
      if (m_timeout_evt) begin
        tevt_count++;
        owner_v = 1'b0;
      end
      next_cycle();
      for (int i = 0; i < NR; i++) if (acc[i]) void'(tq[i].pop_front());
      cyc++;
      done = (exp_fifo.size() == 0) && !m_tx_valid;
      for (int i = 0; i < NR; i++) if (tq[i].size() > 0) done = 1'b0;
    end
    check("stream_drained", 32'(done), 1);
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        txr;
    logic [3:0]  e_rdy;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [1:0]  e_gnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl [6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int total;
    int len;
    logic [7:0] exp_cont [6];

    // Requester 2 sends "hi\n" with tx_ready held high.
    tbl[0] = '{4'b0100, 32'h0068_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1] = '{4'b0100, 32'h0068_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1};
    tbl[2] = '{4'b0100, 32'h0069_0000, 1'b1, 4'b0100, 1'b1, 8'h68, 2'd2, 1'b1};
    tbl[3] = '{4'b0100, 32'h000A_0000, 1'b1, 4'b0100, 1'b1, 8'h69, 2'd2, 1'b1};
    tbl[4] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'h0A, 2'd2, 1'b1};
    tbl[5] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};

    sel = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_tx_valid", 32'(m_tx_valid), 0);
    check("reset_busy", 32'(m_busy), 0);
    check("reset_grant", 32'(m_grant_id), 0);
    check("reset_evt", 32'(m_timeout_evt), 0);
    next_cycle();

    for (int r = 0; r < 6; r++) begin
      req_valid = tbl[r].rv;
      req_data  = tbl[r].rd;
      tx_ready  = tbl[r].txr;
      @(negedge clk);
      check($sformatf("hi_ready[%0d]", r), 32'(m_req_ready), 32'(tbl[r].e_rdy));
      check($sformatf("hi_txv[%0d]", r), 32'(m_tx_valid), 32'(tbl[r].e_txv));
      if (tbl[r].e_txv) check($sformatf("hi_txd[%0d]", r), 32'(m_tx_data), 32'(tbl[r].e_txd));
      check($sformatf("hi_grant[%0d]", r), 32'(m_grant_id), 32'(tbl[r].e_gnt));
      check($sformatf("hi_busy[%0d]", r), 32'(m_busy), 32'(tbl[r].e_busy));
      next_cycle();
    end

    // Back-pressure: byte held for 5 stalled cycles, next byte taken as soon as tx_ready returns.
    do_reset();
    req_valid = 4'b0001; req_data = 32'h31; tx_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("bp_first_ready", 32'(m_req_ready), 32'b0001);
    next_cycle();
    req_data = 32'h32; tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_txv", 32'(m_tx_valid), 1);
      check("bp_txd", 32'(m_tx_data), 32'h31);
      check("bp_ready", 32'(m_req_ready), 0);
      next_cycle();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_ready", 32'(m_req_ready), 32'b0001);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("bp_next_txd", 32'(m_tx_data), 32'h32);
    check("bp_next_txv", 32'(m_tx_valid), 1);

    // Timeout: requester 1 goes quiet after one byte while requester 2 waits.
    do_reset();
    req_valid = 4'b0110; req_data = 32'h0042_4100; tx_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("to_grant", 32'(m_grant_id), 1);
    check("to_ready", 32'(m_req_ready), 32'b0010);
    next_cycle();
    req_valid = 4'b0100;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("to_evt[c%0d]", c), 32'(m_timeout_evt), 32'(c == 10));
      if (c == 11) check("to_regrant", 32'(m_grant_id), 2);
      next_cycle();
    end

    // Reset while requester 1 holds a pending byte under back-pressure.
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_4130; tx_ready = 1'b0;
    next_cycle();
    next_cycle();
    req_valid = 4'b0011;
    @(negedge clk);
    check("rm_pre_txv", 32'(m_tx_valid), 1);
    check("rm_pre_grant", 32'(m_grant_id), 1);
    #2 rst = 1'b1;
    #1;
    check("rm_txv", 32'(m_tx_valid), 0);
    check("rm_busy", 32'(m_busy), 0);
    check("rm_grant", 32'(m_grant_id), 0);
    check("rm_ready", 32'(m_req_ready), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rm_idle_ready", 32'(m_req_ready), 0);
    next_cycle();
    @(negedge clk);
    check("rm_regrant", 32'(m_grant_id), 0);
    check("rm_regrant_ready", 32'(m_req_ready), 32'b0001);

    // Contention: two full lines, never interleaved, then pointer-based re-arbitration.
    do_reset();
    exp_cont = '{8'h41, 8'h42, 8'h0A, 8'h41, 8'h42, 8'h0A};
    tq[0] = '{8'h41, 8'h42, 8'h0A};
    tq[3] = '{8'h41, 8'h42, 8'h0A};
    run_stream(1'b0, 200);
    check("cont_len", src_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < src_log.size()) check($sformatf("cont_src[%0d]", k), src_log[k], (k < 3) ? 0 : 3);
      if (k < out_log.size()) check($sformatf("cont_out[%0d]", k), 32'(out_log[k]), 32'(exp_cont[k]));
    end
    check("cont_no_timeout", tevt_count, 0);
    tq[0] = '{8'h0A};
    run_stream(1'b0, 100);
    tq[0] = '{8'h0A};
    tq[3] = '{8'h0A};
    run_stream(1'b0, 100);
    check("rr_len", src_log.size(), 2);
    if (src_log.size() == 2) begin
      check("rr_first", src_log[0], 3);
      check("rr_second", src_log[1], 0);
    end

    // Per-byte release: two streams alternate byte by byte.
    sel = 1'b1;
    do_reset();
    tq[0] = '{8'h10, 8'h11, 8'h12};
    tq[1] = '{8'h20, 8'h21, 8'h22};
    run_stream(1'b0, 200);
    check("ll0_len", src_log.size(), 6);
    for (int k = 0; k < src_log.size(); k++)
      check($sformatf("ll0_src[%0d]", k), src_log[k], k % 2);
    check("ll0_no_timeout", tevt_count, 0);

    // Randomised lines with random gaps and back-pressure on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      total = 0;
      for (int i = 0; i < NR; i++) begin
        for (int l = 0; l < 3; l++) begin
          len = $urandom_range(1, 5);
          for (int j = 0; j < len; j++) tq[i].push_back(8'($urandom_range(32, 126)));
          tq[i].push_back(EOL);
          total += len + 1;
        end
      end
      run_stream(1'b1, 5000);
      check($sformatf("rnd_count[%0d]", s), out_log.size(), total);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
